// File: rtl/pw_proto_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pw_proto_pkg                                                       |
// | Password-store byte protocol: command codes, ack bytes, FSM types. |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package pw_proto_pkg;

   localparam logic [7:0] CMD_GET = 8'h81;
   localparam logic [7:0] CMD_SET = 8'h01;

   // Element 0 is the first ack byte on the wire ("enoD").
   localparam logic [3:0][7:0] ACK_BYTES = {8'h44, 8'h6F, 8'h6E, 8'h65};

   typedef enum logic [2:0] {
      ST_IDLE         = 3'd0,
      ST_SEND_CMD     = 3'd1,
      ST_SEND_IDX     = 3'd2,
      ST_SEND_PAYLOAD = 3'd3,
      ST_RECV_DATA    = 3'd4,
      ST_RECV_ACK     = 3'd5,
      ST_DONE         = 3'd6
   } state_e;

   typedef enum logic {
      OP_GET = 1'b0,
      OP_SET = 1'b1
   } op_e;

endpackage
`default_nettype wire

// File: rtl/pw_rx_timeout.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pw_rx_timeout                                                      |
// | Idle-cycle counter; expired flags the TIMEOUT_CYCLES-th idle cycle.|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pw_rx_timeout #(
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   logic [TW-1:0] count_q;
   logic [TW-1:0] count_d;
   logic          at_limit;

   assign at_limit = (count_q == TW'(TIMEOUT_CYCLES - 1));
   assign expired  = enable && !clear && at_limit;

   always_comb begin
      count_d = count_q;
      if (clear) begin
         count_d = '0;
      end else if (enable && !at_limit) begin
         count_d = count_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pw_cmd_initiator.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pw_cmd_initiator                                                   |
// | Serialises get/set requests onto UART TX and collects the reply.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module pw_cmd_initiator
   import pw_proto_pkg::*;
#(
   parameter int DATA_WIDTH     = 512,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_op,
   input  logic [7:0]            req_idx,
   input  logic [DATA_WIDTH-1:0] req_data,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_data,
   output logic                  rsp_err,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready
);

   localparam int NBYTES = DATA_WIDTH / 8;
   localparam int CW     = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   state_e                state_q, state_d;
   op_e                   op_q, op_d;
   logic [7:0]            idx_q, idx_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [1:0]            ack_q, ack_d;
   logic                  err_q, err_d;
   logic                  tx_valid_q, tx_valid_d;
   logic [7:0]            tx_data_q, tx_data_d;
   logic                  rsp_valid_q, rsp_valid_d;
   logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
   logic                  rsp_err_q, rsp_err_d;

   logic tx_fire;
   logic in_recv;
   logic to_expired;

   assign tx_fire   = tx_valid_q && tx_ready;
   assign in_recv   = (state_q == ST_RECV_DATA) || (state_q == ST_RECV_ACK);
   assign req_ready = (state_q == ST_IDLE) && !rst;
   assign rx_ready  = 1'b1;
   assign tx_valid  = tx_valid_q;
   assign tx_data   = tx_data_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_err   = rsp_err_q;

   // Counter is held clear outside the receive states, so entry starts at zero.
   pw_rx_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .rst     (rst),
      .clear   (rx_valid || !in_recv),
      .enable  (in_recv),
      .expired (to_expired)
   );

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      idx_d       = idx_q;
      data_d      = data_q;
      word_d      = word_q;
      cnt_d       = cnt_q;
      ack_d       = ack_q;
      err_d       = err_q;
      tx_valid_d  = 1'b0;
      tx_data_d   = tx_data_q;
      rsp_valid_d = 1'b0;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               op_d       = op_e'(req_op);
               idx_d      = req_idx;
               data_d     = req_data;
               word_d     = '0;
               cnt_d      = '0;
               ack_d      = '0;
               err_d      = 1'b0;
               state_d    = ST_SEND_CMD;
               tx_valid_d = 1'b1;
               tx_data_d  = req_op ? CMD_SET : CMD_GET;
            end
         end
         ST_SEND_CMD: begin
            tx_valid_d = 1'b1;
            if (tx_fire) begin
               state_d   = ST_SEND_IDX;
               tx_data_d = idx_q;
            end
         end
         ST_SEND_IDX: begin
            tx_valid_d = 1'b1;
            if (tx_fire) begin
               if (op_q == OP_SET) begin
                  state_d   = ST_SEND_PAYLOAD;
                  tx_data_d = data_q[7:0];
               end else begin
                  state_d    = ST_RECV_DATA;
                  tx_valid_d = 1'b0;
                  tx_data_d  = '0;
               end
            end
         end
         ST_SEND_PAYLOAD: begin
            tx_valid_d = 1'b1;
            if (tx_fire) begin
               data_d = data_q >> 8;
               if (cnt_q == CW'(NBYTES - 1)) begin
                  state_d    = ST_RECV_ACK;
                  cnt_d      = '0;
                  tx_valid_d = 1'b0;
                  tx_data_d  = '0;
               end else begin
                  cnt_d     = cnt_q + 1'b1;
                  tx_data_d = data_d[7:0];
               end
            end
         end
         ST_RECV_DATA: begin
            if (rx_valid) begin
               word_d[8*cnt_q +: 8] = rx_data;
               if (cnt_q == CW'(NBYTES - 1)) begin
                  state_d = ST_DONE;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end else if (to_expired) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end
         end
         ST_RECV_ACK: begin
            if (rx_valid) begin
               if (rx_data != ACK_BYTES[ack_q]) begin
                  err_d = 1'b1;
               end
               if (ack_q == 2'd3) begin
                  state_d = ST_DONE;
                  ack_d   = '0;
               end else begin
                  ack_d = ack_q + 1'b1;
               end
            end else if (to_expired) begin
               state_d = ST_DONE;
               err_d   = 1'b1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // DONE always returns to IDLE, so this fires exactly once per response.
      if (state_d == ST_DONE) begin
         rsp_valid_d = 1'b1;
         rsp_err_d   = err_d;
         rsp_data_d  = (op_q == OP_SET) ? '0 : word_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         op_q        <= OP_GET;
         idx_q       <= '0;
         data_q      <= '0;
         word_q      <= '0;
         cnt_q       <= '0;
         ack_q       <= '0;
         err_q       <= 1'b0;
         tx_valid_q  <= 1'b0;
         tx_data_q   <= '0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         idx_q       <= idx_d;
         data_q      <= data_d;
         word_q      <= word_d;
         cnt_q       <= cnt_d;
         ack_q       <= ack_d;
         err_q       <= err_d;
         tx_valid_q  <= tx_valid_d;
         tx_data_q   <= tx_data_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
      end
   end

endmodule
`default_nettype wire

// File: doc/pw_cmd_initiator.md
Name: pw_cmd_initiator

Overview:
- Host-side initiator for the password-store byte protocol. It turns one parallel request (get or set a slot) into a UART TX byte stream, then collects the UART RX reply.
- Get: reassembles the returned password word. Set: checks the 4-byte done-ack.
- Sits between a test/loopback controller and the UART TX/RX byte interfaces, facing the password-store command logic across the link.

Parameters:
- DATA_WIDTH, 512, payload bits per slot; must be a multiple of 8; NBYTES = DATA_WIDTH/8.
- TIMEOUT_CYCLES, 1000000, max idle clk cycles between reply bytes before abort.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept request (IDLE only)
- req_op  in  1  0 = get, 1 = set
- req_idx  in  8  slot index
- req_data  in  DATA_WIDTH  payload for set; ignored for get
- rsp_valid  out  1  one-cycle pulse, response complete
- rsp_data  out  DATA_WIDTH  received password (get); all-zero for set
- rsp_err  out  1  qualified by rsp_valid; ack mismatch or timeout
- tx_data  out  8  byte to UART TX
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  UART TX accepts byte
- rx_data  in  8  byte from UART RX
- rx_valid  in  1  rx_data valid
- rx_ready  out  1  constant 1 after reset; UART RX cannot be stalled

Behaviour:
- Transfer rules:
  - TX byte transfers when tx_valid && tx_ready.
  - tx_data must stay stable while tx_valid=1 and tx_ready=0.
  - Request accepted when req_valid && req_ready. req_op, req_idx and req_data are captured into internal registers on acceptance.
- Reset values: req_ready=0 during rst, then 1 in IDLE; tx_valid=0; tx_data=0; rsp_valid=0; rsp_err=0; rsp_data=0; rx_ready=1; state=IDLE; counters=0.
- Reset mid-operation: abort immediately to IDLE with no rsp_valid; the partial word is discarded.
- States:
  - IDLE: req_ready=1. On accept -> SEND_CMD.
  - SEND_CMD: tx_data=CMD_GET (8'h81) if get, CMD_SET (8'h01) if set. On transfer -> SEND_IDX.
  - SEND_IDX: tx_data=captured idx. On transfer: get -> RECV_DATA; set -> SEND_PAYLOAD.
  - SEND_PAYLOAD: tx_data = data[8*k +: 8] for k = 0..NBYTES-1, LSB byte first; k increments per transfer. After byte NBYTES-1 -> RECV_ACK.
  - RECV_DATA: rx byte k is stored to word[8*k +: 8], LSB byte first. After byte NBYTES-1 -> DONE with err=0.
  - RECV_ACK: expects 8'h65, 8'h6E, 8'h6F, 8'h44 in order.
    - Any mismatch sets a sticky err flag, but all 4 bytes are still consumed.
    - After the 4th byte -> DONE.
  - DONE: rsp_valid=1 for exactly one cycle with rsp_data and rsp_err driven -> IDLE.
    - rsp_data/rsp_err hold their values until the next DONE.
    - req_ready stays 0 in this cycle.
- tx_valid is 1 only in SEND_* states. It is registered and asserts the cycle after entering the state.
- Back-to-back TX bytes are allowed with no bubble when tx_ready is held high.
- Timeout:
  - A cycle counter runs in RECV_DATA/RECV_ACK. It clears on entry and on every rx_valid.
  - Reaching TIMEOUT_CYCLES -> DONE with rsp_err=1; rsp_data holds the partial word.
- RX bytes arriving in IDLE or SEND_* states are dropped and do not affect the next reply.
- Byte counter width: clog2(NBYTES); it must not wrap before the terminal compare.
- rx_valid and a timeout in the same cycle: the byte wins and the counter clears.

Decomposition:
- Package pw_proto_pkg holds:
  - CMD_GET/CMD_SET constants
  - ACK byte array {8'h65, 8'h6E, 8'h6F, 8'h44}
  - state enum typedef
  - op enum typedef {OP_GET, OP_SET}
- Optional sub-module pw_rx_timeout: counter with clear/enable/expired. It is shared with the responder side.

Test Plan:
- Get, idx=8'h05, tx_ready=1, responder returns bytes 8'h00..8'h3F -> TX stream 81,05; rsp_valid one cycle; rsp_data[7:0]=00, rsp_data[511:504]=3F; rsp_err=0.
- Set, idx=8'h00, req_data=512'h4675636b; reply 65,6E,6F,44 -> TX stream:
  - 01, 00
  - 6B, 63, 75, 46
  - 60 zero bytes
  - Result: rsp_err=0, rsp_data=0.
- Set with ack 65,6E,6F,45 -> rsp_err=1 after the 4th byte, not earlier.
- tx_ready toggling 1-0-0-1 during SEND_PAYLOAD -> no duplicated or skipped bytes; tx_data stable while stalled.
- Get, TIMEOUT_CYCLES=100, responder sends 10 bytes then stops -> rsp_err=1 exactly 100 cycles after the 10th byte; rsp_data[79:0] holds the received bytes.
- rst asserted during RECV_DATA byte 20 -> next cycle tx_valid=0 and req_ready=1 (after deassert); no rsp_valid. A following get completes normally.
